// File: rtl/serial_adder_n_pkg.sv
// Purpose : shared FSM encodings and elaboration helpers for the serial adder.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package serial_adder_n_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Ceiling log2, usable in parameter expressions; clog2(1) == 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_n_digit_adder.sv
// Purpose : DIGIT-bit ripple-carry adder built from full-adder cells.
// Latency : purely combinational.
// Backpr. : none (no handshake).
// Ports   : a, b (DIGIT) operands; cin carry-in; s (DIGIT) sum;
//           cout carry out of the top bit; c_msb carry into the top bit.
module serial_adder_n_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[DIGIT];
    // Carry into the most significant bit; XOR with cout gives signed overflow.
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// Purpose : digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock, LSB first.
// Latency : start accepted at edge 0, done pulses after edge N (N = WIDTH/DIGIT).
// Backpr. : start accepted only in IDLE/DONE; ignored while busy.
// Ports   : clk, rst_n (async active-low); start, sub, a, b, cin request;
//           busy, done status; sum, cout, ovf result (held until next accepted start).
module serial_adder_n
    import serial_adder_n_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_adder_n: WIDTH must be a multiple of DIGIT");
    end

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic            carry;

    logic [DIGIT-1:0] d_s;
    logic             d_cout;
    logic             d_cmsb;

    logic accept;
    logic last;

    // New digits enter the sum register at the MSB end so that after N
    // shifts the first (least significant) digit has reached bit 0.
    logic [WIDTH+DIGIT-1:0] sum_cat;

    assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
    assign last    = (state == S_RUN) && (count == CW'(N - 1));
    assign sum_cat = {d_s, sum};

    serial_adder_n_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (a_sr[DIGIT-1:0]),
        .b     (b_sr[DIGIT-1:0]),
        .cin   (carry),
        .s     (d_s),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:          state_nxt = last ? S_DONE : S_RUN;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: DONE lasts exactly one cycle, so done is a single pulse
    // and can never overlap busy.
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Datapath: operand shifters, carry flop, counter and result registers.
    // Subtraction is a + ~b + ~cin, i.e. a - b - cin modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            count <= '0;
        end else if (state == S_RUN) begin
            a_sr  <= a_sr >> DIGIT;
            b_sr  <= b_sr >> DIGIT;
            carry <= d_cout;
            sum   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
            count <= count + CW'(1);
            if (last) begin
                cout <= d_cout;
                ovf  <= d_cout ^ d_cmsb;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;

    logic        clk;
    logic        rst_n;

    logic        start1, sub1, cin1, busy1, done1, cout1, ovf1;
    logic [15:0] a1, b1, sum1;
    logic        start4, sub4, cin4, busy4, done4, cout4, ovf4;
    logic [15:0] a4, b4, sum4;

    int vectors;
    int miscompares;

    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;

    serial_adder_n #(.WIDTH(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder_n #(.WIDTH(16), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void ref_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, output logic [15:0] r,
                                   output logic co, output logic ov);
        int ux, uy, sx, sy, c, t, st;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        c  = ci ? 1 : 0;
        if (!s) begin
            t  = ux + uy + c;
            co = (t >= 65536);
            st = sx + sy + c;
        end else begin
            t  = ux - uy - c;
            co = (ux >= uy + c);
            st = sx - sy - c;
        end
        r  = t[15:0];
        ov = (st > 32767) || (st < -32768);
    endfunction

    // Called at a negedge; the start is sampled at the following posedge.
    task automatic launch(input bit w, input logic s, input logic [15:0] x,
                          input logic [15:0] y, input logic ci);
        ref_op(s, x, y, ci, exp_sum, exp_cout, exp_ovf);
        if (!w) begin
            sub1 = s; a1 = x; b1 = y; cin1 = ci; start1 = 1'b1;
        end else begin
            sub4 = s; a4 = x; b4 = y; cin4 = ci; start4 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        check("busy_on", {31'd0, (w ? busy4 : busy1)}, 32'd1);
        check("done_off", {31'd0, (w ? done4 : done1)}, 32'd0);
    endtask

    // Waits for done while scrambling operands; optionally pulses start
    // with fresh operands at RUN cycle 'glitch'. Returns at the done negedge.
    task automatic finish(input bit w, input int lat, input int glitch, input string tag);
        int cyc;
        cyc = 0;
        while (!(w ? done4 : done1) && cyc < 64) begin
            if (!w) begin
                a1 = 16'($urandom); b1 = 16'($urandom);
                sub1 = 1'($urandom); cin1 = 1'($urandom);
                start1 = (cyc == glitch);
            end else begin
                a4 = 16'($urandom); b4 = 16'($urandom);
                sub4 = 1'($urandom); cin4 = 1'($urandom);
                start4 = (cyc == glitch);
            end
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0;
        start4 = 1'b0;
        check({tag, "_lat"},  cyc, lat);
        check({tag, "_sum"},  {16'd0, (w ? sum4 : sum1)}, {16'd0, exp_sum});
        check({tag, "_cout"}, {31'd0, (w ? cout4 : cout1)}, {31'd0, exp_cout});
        check({tag, "_ovf"},  {31'd0, (w ? ovf4 : ovf1)}, {31'd0, exp_ovf});
        check({tag, "_busy"}, {31'd0, (w ? busy4 : busy1)}, 32'd0);
    endtask

    task automatic run_op(input bit w, input logic s, input logic [15:0] x,
                          input logic [15:0] y, input logic ci, input int glitch,
                          input string tag);
        @(negedge clk);
        launch(w, s, x, y, ci);
        finish(w, w ? 4 : 16, glitch, tag);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, (w ? done4 : done1)}, 32'd0);
        check({tag, "_hold"},  {16'd0, (w ? sum4 : sum1)}, {16'd0, exp_sum});
    endtask

    initial begin
        int dn;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start1 = 0; sub1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        start4 = 0; sub4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", {30'd0, busy1, busy4}, 32'd0);
        check("rst_done", {30'd0, done1, done4}, 32'd0);
        check("rst_sum",  {sum1, sum4}, 32'd0);
        check("rst_flags", {28'd0, cout1, ovf1, cout4, ovf4}, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op(0, 1'b0, 16'h1234, 16'h4321, 1'b0, -1, "add_basic");
        check("add_basic_const", {16'd0, sum1}, 32'h5555);
        run_op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, -1, "add_wrap");
        check("add_wrap_const", {15'd0, cout1, sum1}, 32'h10000);
        run_op(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, -1, "add_ovf");
        check("add_ovf_const", {15'd0, ovf1, sum1}, 32'h18000);
        run_op(0, 1'b1, 16'h0005, 16'h0007, 1'b0, -1, "sub_borrow");
        check("sub_borrow_const", {15'd0, cout1, sum1}, 32'h0FFFE);
        run_op(0, 1'b1, 16'h0009, 16'h0003, 1'b1, -1, "sub_bin");
        check("sub_bin_const", {15'd0, cout1, sum1}, 32'h10005);
        run_op(0, 1'b0, 16'h1111, 16'h2222, 1'b1, 5, "start_in_run");

        // Mid-operation reset
        @(negedge clk);
        launch(0, 1'b0, 16'hF0F0, 16'h0F0F, 1'b1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy1}, 32'd0);
        check("midrst_out", {14'd0, done1, cout1, sum1}, 32'd0);
        check("midrst_ovf", {31'd0, ovf1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done1) dn++;
        end
        check("midrst_nodone", dn, 0);
        run_op(0, 1'b1, 16'h8000, 16'h0001, 1'b0, -1, "after_rst");

        // DIGIT=4 with back-to-back start in DONE
        @(negedge clk);
        launch(1, 1'b0, 16'hABCD, 16'h1111, 1'b0);
        finish(1, 4, -1, "d4_first");
        check("d4_first_const", {16'd0, sum4}, 32'hBCDE);
        launch(1, 1'b1, 16'h1000, 16'h2000, 1'b0);
        finish(1, 4, -1, "d4_b2b");

        // Randomized
        for (int i = 0; i < 30; i++) begin
            run_op(0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), -1, "rnd1");
        end
        for (int i = 0; i < 20; i++) begin
            run_op(1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), "rnd4");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
